disp_arbiter: RTL and testbench
===============================

// Module: disp_arbiter
// PURPOSE
//  Shares the single 4-digit 7-segment display driver (disp_num) between N
//  requesters, e.g. counter value, ripple-carry status and a debug word.
//  Fair round-robin arbiter with a minimum on-screen hold time in tick pulses.
//  Sits between the requesters and disp_num; its outputs feed HEXS/point/LES.
// PARAMETERS
//  N           4   number of requesters (2..8)
//  HOLD_TICKS  3   minimum ticks an owner keeps the display once others wait (>=1)
// PORTS
//  clk      in   1     system clock; the only clock
//  RST      in   1     synchronous, active-high reset
//  tick     in   1     one-cycle enable pulse (e.g. 1 s divider), hold timebase
//  req      in   N     req[i]=1: requester i wants the display; level, not pulse
//  hex_in   in   16*N  requester i digits at [16i+15:16i]
//  point_in in   4*N   requester i decimal points at [4i+3:4i]
//  les_in   in   4*N   requester i digit blank mask at [4i+3:4i] (1 = blank)
//  gnt      out  N     one-hot current owner; all-zero when idle
//  busy     out  1     1 while any requester owns the display
//  HEXS     out  16    to disp_num HEXS
//  point    out  4     to disp_num point
//  LES      out  4     to disp_num LES
// BEHAVIOUR
//  - Reset (RST=1 at posedge): gnt=0, busy=0, HEXS=0, point=0, LES=4'hF,
//    hold counter=0, last-owner pointer=N-1 (so req[0] has priority first).
//  - States: IDLE (no owner), OWN (owner k held in register).
//  - IDLE: if req!=0, next cycle grant to first set bit searching
//    last+1, last+2, ... (mod N); load hold=HOLD_TICKS; go OWN. Else stay.
//  - OWN, owner k:
//    * req[k]=0 -> release in that cycle; if other reqs, grant the next one by
//      round-robin from k+1 in the same edge (no idle gap), else IDLE.
//      Owner dropping beats a simultaneous tick.
//    * req[k]=1, hold>0: decrement hold on tick only; no switch.
//    * req[k]=1, hold==0, another req set: switch to next by round-robin
//      from k+1, reload hold=HOLD_TICKS, last=k.
//    * req[k]=1, hold==0, no other req: keep k; hold stays 0, no wrap.
//  - Hold counter width $clog2(HOLD_TICKS+1); saturates at 0, never underflows.
//  - Data path registered, 1-cycle latency: each cycle HEXS/point/LES <= the
//    slice of the owner registered after this edge. Owner data changes pass
//    through live. IDLE: HEXS=0, point=0, LES=4'hF (display fully blank).
//  - gnt, busy and data outputs change on the same edge; gnt never two-hot.
//  - Requests from out-of-range or X-free reqs only; req bits are sampled
//    directly (they come from the clk domain).
//  - RST mid-ownership: aborts immediately, outputs return to reset values.
// STRUCTURE
//  - disp_defs.vh: LES_BLANK=4'hF, state codes ST_IDLE/ST_OWN, digit width 4.
//  - Sub-module rr_pick (combinational, parameter N): in req, base index ->
//    out valid, one-hot pick and index of first set bit at/after base, mod N.
//    Used for both the IDLE grant and the OWN switch.
//  - Top: state/owner/last/hold registers plus registered output mux.
// TESTING
//  1 Reset, req=0 -> gnt=0, busy=0, LES=4'hF, HEXS=0 held for 20 cycles.
//  2 Reset, then req=4'b0101 -> gnt=0001 one cycle later, HEXS=hex_in[15:0];
//    after 3 ticks plus 1 cycle -> gnt=0100, HEXS=hex_in[47:32].
//  3 Owner 0 with req=0001 only, 10 ticks -> gnt stays 0001. Raising req[3]
//    -> gnt=1000 on next cycle (hold already 0).
//  4 Owner 2, hold=2, drop req[2] on the same cycle as tick with req[1]=1
//    -> gnt=0010 next cycle, hold reloaded to 3.
//  5 Fairness: req=4'b1111 constant for 12 ticks -> grant order 0,1,2,3,0
//    with 3 ticks each.
//  6 RST pulse while gnt=0100 -> next cycle gnt=0, LES=4'hF; with req=1111
//    the first grant is gnt=0001.

Source files
------------

// File: rtl/disp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// disp_arbiter_pkg
// Purpose : shared definitions for the display arbiter. These are the digit
//           geometry of the 4-digit 7-segment driver, the blank-digit mask and
//           the arbiter state encoding.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package disp_arbiter_pkg;

  // One hex digit is one nibble, and the display has four digits.
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int HEX_W      = DIGIT_W * NUM_DIGITS;

  // An LES bit set to 1 blanks that digit, so an all-ones mask blanks the
  // whole display.
  localparam logic [NUM_DIGITS-1:0] LES_BLANK = 4'hF;

  // ST_IDLE means nobody owns the display.
  // ST_OWN means the owner index register is valid.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : combinational round-robin search. It finds the first set bit of
//           req, starting at index base and wrapping modulo N.
// Ports   : req    in  N        request vector
//           base   in  clog2(N) index where the search starts
//           valid  out 1        at least one request bit is set
//           pick   out N        one-hot copy of the winning request
//           idx    out clog2(N) index of the winning request
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic                 valid,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] NW = (IW+1)'(N);

  // Walk the N candidates in priority order: base, base+1, ... wrapping at N.
  // The sum carries one extra bit so that the wrap test also works for N
  // values that are not a power of two.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    sum   = '0;
    cand  = '0;
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, base} + (IW+1)'(i);
      if (sum >= NW) begin
        sum = sum - NW;
      end
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// -----------------------------------------------------------------------------
// disp_arbiter
// Purpose : shares one 4-digit 7-segment driver between N requesters. It uses
//           fair round-robin arbitration. Once others are waiting, an owner
//           keeps the display for at least HOLD_TICKS tick pulses.
// Ports   : clk       in  1      system clock
//           RST       in  1      synchronous active-high reset
//           tick      in  1      one-cycle hold timebase pulse
//           req       in  N      level request per requester
//           hex_in    in  16*N   digits of requester i at [16i+15:16i]
//           point_in  in  4*N    decimal points of requester i at [4i+3:4i]
//           les_in    in  4*N    blank mask of requester i at [4i+3:4i]
//           gnt       out N      one-hot owner, zero when idle
//           busy      out 1      a requester owns the display
//           HEXS      out 16     digits to the display driver
//           point     out 4      decimal points to the display driver
//           LES       out 4      blank mask to the display driver
// -----------------------------------------------------------------------------
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    tick,
  input  logic [N-1:0]            req,
  input  logic [HEX_W*N-1:0]      hex_in,
  input  logic [NUM_DIGITS*N-1:0] point_in,
  input  logic [NUM_DIGITS*N-1:0] les_in,
  output logic [N-1:0]            gnt,
  output logic                    busy,
  output logic [HEX_W-1:0]        HEXS,
  output logic [NUM_DIGITS-1:0]   point,
  output logic [NUM_DIGITS-1:0]   LES
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [HW-1:0] hold;

  logic [IW-1:0] cur;
  logic [IW-1:0] base;
  logic          pick_valid;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;

  logic          nxt_valid;
  logic [IW-1:0] nxt_idx;
  logic          reload;
  logic          handoff;

  logic [HEX_W-1:0]      sel_hex;
  logic [NUM_DIGITS-1:0] sel_point;
  logic [NUM_DIGITS-1:0] sel_les;

  // Search starts just after the previous owner when idle, and just after the
  // current owner when owned. If the search lands on the current owner, no
  // other requester is waiting.
  always_comb begin
    cur  = (state == ST_IDLE) ? last : owner;
    base = (cur == LAST_IDX) ? '0 : cur + 1'b1;
  end

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .base  (base),
    .valid (pick_valid),
    .pick  (pick_onehot),
    .idx   (pick_idx)
  );

  // Decide who owns the display after this edge. A dropped request hands off
  // immediately, even if a tick arrives in the same cycle. An expired hold
  // only switches when the search finds a requester other than the owner.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_idx   = owner;
    reload    = 1'b0;
    handoff   = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_valid = pick_valid;
        nxt_idx   = pick_idx;
        reload    = pick_valid;
      end
      ST_OWN: begin
        if (!req[owner]) begin
          nxt_valid = pick_valid;
          nxt_idx   = pick_idx;
          reload    = pick_valid;
          handoff   = 1'b1;
        end else if ((hold == '0) && (pick_idx != owner)) begin
          nxt_valid = 1'b1;
          nxt_idx   = pick_idx;
          reload    = 1'b1;
          handoff   = 1'b1;
        end else begin
          nxt_valid = 1'b1;
        end
      end
      default: begin
        nxt_valid = 1'b0;
      end
    endcase
  end

  // Slice out the data of the next owner. The slice is taken every cycle, so
  // changes to the owner's data reach the display one cycle later.
  always_comb begin
    sel_hex   = hex_in[{nxt_idx, 4'b0000} +: HEX_W];
    sel_point = point_in[{nxt_idx, 2'b00} +: NUM_DIGITS];
    sel_les   = les_in[{nxt_idx, 2'b00} +: NUM_DIGITS];
  end

  // This block holds the state, owner, last-owner pointer and hold counter,
  // plus the registered outputs. gnt only changes when a new grant is loaded,
  // so it is always a copy of one rr_pick one-hot vector or zero.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= LAST_IDX;
      hold  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      HEXS  <= '0;
      point <= '0;
      LES   <= LES_BLANK;
    end else begin
      state <= nxt_valid ? ST_OWN : ST_IDLE;
      owner <= nxt_idx;
      if (handoff) begin
        last <= owner;
      end
      if (reload) begin
        hold <= HOLD_INIT;
      end else if (!nxt_valid) begin
        hold <= '0;
      end else if (tick && (hold != '0)) begin
        hold <= hold - 1'b1;
      end
      if (!nxt_valid) begin
        gnt <= '0;
      end else if (reload) begin
        gnt <= pick_onehot;
      end
      busy  <= nxt_valid;
      HEXS  <= nxt_valid ? sel_hex   : '0;
      point <= nxt_valid ? sel_point : '0;
      LES   <= nxt_valid ? sel_les   : LES_BLANK;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_disp_arbiter
// Purpose : self-checking bench for disp_arbiter (N=4, HOLD_TICKS=3).
//           Each step drives one cycle of inputs and pushes the expected
//           post-edge outputs onto a scoreboard queue. After the edge, the
//           front of the queue is popped and compared with the DUT outputs.
// Ports   : none
// -----------------------------------------------------------------------------
module tb_disp_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic        tick;
  logic [3:0]  req;
  logic [63:0] hex_in;
  logic [15:0] point_in;
  logic [15:0] les_in;
  logic [3:0]  gnt;
  logic        busy;
  logic [15:0] HEXS;
  logic [3:0]  point;
  logic [3:0]  LES;

  typedef struct {
    logic [3:0]  gnt;
    logic        busy;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       tick;
    logic [3:0] expGnt;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  logic [15:0] hexVal [N];
  logic [3:0]  ptVal  [N];
  logic [3:0]  lesVal [N];

  int testsRun    = 0;
  int testsFailed = 0;

  disp_arbiter #(
    .N          (4),
    .HOLD_TICKS (3)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .tick     (tick),
    .req      (req),
    .hex_in   (hex_in),
    .point_in (point_in),
    .les_in   (les_in),
    .gnt      (gnt),
    .busy     (busy),
    .HEXS     (HEXS),
    .point    (point),
    .LES      (LES)
  );

  // The free-running clock has a 10-unit period.
  always #5 clk = ~clk;

  // Pack the per-requester data tables onto the wide input buses.
  task automatic packData();
    for (int i = 0; i < N; i++) begin
      hex_in[16*i +: 16]  = hexVal[i];
      point_in[4*i +: 4]  = ptVal[i];
      les_in[4*i +: 4]    = lesVal[i];
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs for after the
  // edge. The data fields come from the bench's own tables for the owner
  // named in expGnt. When nobody owns the display, it is blank.
  task automatic applyStimulus(input logic rstIn, input logic [3:0] reqIn,
                               input logic tickIn, input logic [3:0] expGnt,
                               input string name);
    exp_t e;
    RST  = rstIn;
    req  = reqIn;
    tick = tickIn;
    packData();
    e.gnt   = expGnt;
    e.busy  = |expGnt;
    e.hexs  = 16'h0000;
    e.point = 4'h0;
    e.les   = 4'hF;
    e.name  = name;
    for (int i = 0; i < N; i++) begin
      if (expGnt[i]) begin
        e.hexs  = hexVal[i];
        e.point = ptVal[i];
        e.les   = lesVal[i];
      end
    end
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    testsRun++;
    if (sb.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty: got nothing queued, want one entry");
    end else begin
      e = sb.pop_front();
      if (gnt !== e.gnt || busy !== e.busy || HEXS !== e.hexs ||
          point !== e.point || LES !== e.les) begin
        testsFailed++;
        $display("[TB] FAIL %s: got gnt=%b busy=%b HEXS=%h point=%h LES=%h, want gnt=%b busy=%b HEXS=%h point=%h LES=%h",
                 e.name, gnt, busy, HEXS, point, LES,
                 e.gnt, e.busy, e.hexs, e.point, e.les);
      end
    end
  endtask

  // Run one cycle: drive the inputs, let the edge pass, then sample 1 unit
  // after the edge.
  task automatic step(input logic rstIn, input logic [3:0] reqIn,
                      input logic tickIn, input logic [3:0] expGnt,
                      input string name);
    applyStimulus(rstIn, reqIn, tickIn, expGnt, name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input logic [3:0] r, input logic t,
                        input logic [3:0] g, input string n);
    vec_t v;
    v.req    = r;
    v.tick   = t;
    v.expGnt = g;
    v.name   = n;
    vecs.push_back(v);
  endtask

  // The main test sequence.
  initial begin
    // Main vector table, which starts from a freshly reset arbiter.
    // Two-way round robin with hold expiry (0 -> 2).
    addVec(4'b0101, 1'b0, 4'b0001, "t2_first_grant");
    addVec(4'b0101, 1'b1, 4'b0001, "t2_tick1");
    addVec(4'b0101, 1'b0, 4'b0001, "t2_notick");
    addVec(4'b0101, 1'b1, 4'b0001, "t2_tick2");
    addVec(4'b0101, 1'b1, 4'b0001, "t2_tick3");
    addVec(4'b0101, 1'b0, 4'b0100, "t2_switch_to2");
    // Lone owner keeps the display while hold saturates at zero.
    addVec(4'b0100, 1'b1, 4'b0100, "t3_lone_tick1");
    addVec(4'b0100, 1'b1, 4'b0100, "t3_lone_tick2");
    addVec(4'b0100, 1'b1, 4'b0100, "t3_lone_tick3");
    addVec(4'b0100, 1'b1, 4'b0100, "t3_lone_sat1");
    addVec(4'b0100, 1'b1, 4'b0100, "t3_lone_sat2");
    addVec(4'b1100, 1'b0, 4'b1000, "t3_new_req_immediate");
    addVec(4'b0000, 1'b0, 4'b0000, "release_to_idle");
    // Fairness: all four requesting, three ticks each, order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      addVec(4'b1111, 1'b0, 4'(1 << (k % 4)), "t5_grant");
      if (k < 4) begin
        for (int t = 0; t < 3; t++) begin
          addVec(4'b1111, 1'b1, 4'(1 << (k % 4)), "t5_hold_tick");
        end
      end
    end

    hexVal = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    ptVal  = '{4'h1, 4'h2, 4'h4, 4'h8};
    lesVal = '{4'h0, 4'h3, 4'h5, 4'h6};
    RST  = 1'b1;
    req  = 4'b0000;
    tick = 1'b0;
    packData();
    @(posedge clk);
    @(posedge clk);
    #1;

    // Test 1: reset state, then idle with no requests for 20 cycles.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "t1_reset");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0000, (i % 3) == 0, 4'b0000, "t1_idle");
    end

    // Table-driven main sequence.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "main_reset");
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].req, vecs[i].tick, vecs[i].expGnt, vecs[i].name);
    end

    // Test 4: owner 2 drops its request on the same cycle as a tick. Then
    // check that the new owner's hold was reloaded to three ticks. The
    // middle of this sequence also changes owner 2's digits to check that
    // owner data passes through live.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "t4_reset");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, "t4_own2");
    hexVal[2] = 16'hC0DE;
    step(1'b0, 4'b0100, 1'b1, 4'b0100, "t4_live_data_hold2");
    hexVal[2] = 16'h9ABC;
    step(1'b0, 4'b0010, 1'b1, 4'b0010, "t4_drop_beats_tick");
    step(1'b0, 4'b0011, 1'b1, 4'b0010, "t4_reload_tick1");
    step(1'b0, 4'b0011, 1'b1, 4'b0010, "t4_reload_tick2");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, "t4_reload_wait");
    step(1'b0, 4'b0011, 1'b1, 4'b0010, "t4_reload_tick3");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, "t4_switch_wraps_to0");

    // Test 6: a reset in the middle of ownership aborts it, and priority
    // restarts at requester 0.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, "t6_reset");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, "t6_own2");
    step(1'b0, 4'b0100, 1'b1, 4'b0100, "t6_own2_tick");
    step(1'b1, 4'b1111, 1'b0, 4'b0000, "t6_rst_mid_own");
    step(1'b0, 4'b1111, 1'b0, 4'b0001, "t6_first_grant_req0");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
